// File: rtl/uart_pkg.sv
// Shared definitions for the UART subsystem: data width, TX FIFO depth and
// the sticky status flag bundle.
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_TXFIFO_DEPTH = 16;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic tx_empty_int;
    } uart_txf_flags_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register array with one synchronous write port and one
// asynchronous read port.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = UART_TXFIFO_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_uart,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // NOTE: storage is deliberately left unreset; validity is tracked by the
    // pointers, and a reset here would turn the array into far costlier flops.
    always_ff @(posedge clk_uart) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO between the CPU SBUF write path and the
// UART transmitter, with sticky overflow/underflow/drained flags.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = UART_TXFIFO_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_uart,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              fifo_full,
    input  logic              r_en,
    output logic [DATA_W-1:0] txd_from_fifo,
    output logic              fifo_empty,
    output logic [ADDR_W:0]   count,
    output logic              ovf,
    output logic              unf,
    output logic              tx_empty_int,
    input  logic              flag_clr
);

    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    uart_txf_flags_t   flags_q, flags_d, flags_set;
    logic              push_ok, pop_ok;
    logic [DATA_W-1:0] head_data;

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_uart (clk_uart),
        .we       (push_ok),
        .waddr    (wr_ptr_q[ADDR_W-1:0]),
        .wdata    (wr_data),
        .raddr    (rd_ptr_q[ADDR_W-1:0]),
        .rdata    (head_data)
    );

    always_comb begin
        // NOTE: every signal gets a default before any condition, so no path
        // through this block can leave one unassigned and infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // A full FIFO still takes a push when the same cycle pops a byte.
        push_ok = wr_en && (!full_q || r_en);
        pop_ok  = r_en && !empty_q;

        if (push_ok) wr_ptr_d = wr_ptr_q + ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + ONE;

        if (push_ok && !pop_ok) begin
            count_d = count_q + ONE;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - ONE;
        end

        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
                  (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);

        flags_set.ovf          = wr_en && full_q && !r_en;
        flags_set.unf          = r_en && empty_q;
        flags_set.tx_empty_int = pop_ok && !push_ok && (count_q == ONE);

        // A set event in the same cycle as flag_clr wins.
        flags_d = flags_set | (flags_q & {3{~flag_clr}});
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order or process scheduling.
    always_ff @(posedge clk_uart or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            flags_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            flags_q  <= flags_d;
        end
    end

    assign txd_from_fifo = empty_q ? '0 : head_data;
    assign fifo_full     = full_q;
    assign fifo_empty    = empty_q;
    assign count         = count_q;
    assign ovf           = flags_q.ovf;
    assign unf           = flags_q.unf;
    assign tx_empty_int  = flags_q.tx_empty_int;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a queue-based reference model predicts
// popped bytes, occupancy and sticky flags for directed and random traffic.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = UART_TXFIFO_DEPTH;

    logic       clk_uart = 1'b0;
    logic       rst;
    logic       wr_en;
    uart_byte_t wr_data;
    logic       fifo_full;
    logic       r_en;
    uart_byte_t txd_from_fifo;
    logic       fifo_empty;
    logic [4:0] count;
    logic       ovf;
    logic       unf;
    logic       tx_empty_int;
    logic       flag_clr;

    int checks = 0;
    int errors = 0;

    uart_byte_t model_q[$];
    uart_byte_t sb_q[$];
    logic       m_ovf, m_unf, m_int;

    uart_tx_fifo dut (
        .clk_uart      (clk_uart),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .fifo_full     (fifo_full),
        .r_en          (r_en),
        .txd_from_fifo (txd_from_fifo),
        .fifo_empty    (fifo_empty),
        .count         (count),
        .ovf           (ovf),
        .unf           (unf),
        .tx_empty_int  (tx_empty_int),
        .flag_clr      (flag_clr)
    );

    always #5 clk_uart = ~clk_uart;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        uart_byte_t exp_head;
        exp_head = (model_q.size() > 0) ? model_q[0] : 8'h00;
        check({tag, " count"}, 32'(count), 32'(model_q.size()));
        check({tag, " fifo_empty"}, 32'(fifo_empty), 32'(model_q.size() == 0));
        check({tag, " fifo_full"}, 32'(fifo_full), 32'(model_q.size() == DEPTH));
        check({tag, " ovf"}, 32'(ovf), 32'(m_ovf));
        check({tag, " unf"}, 32'(unf), 32'(m_unf));
        check({tag, " tx_empty_int"}, 32'(tx_empty_int), 32'(m_int));
        check({tag, " head"}, 32'(txd_from_fifo), 32'(exp_head));
    endtask

    // Drives one cycle at posedge+1, predicts its effect, then checks after the edge.
    task automatic step(input logic we, input uart_byte_t wd, input logic re,
                        input logic fc, input string tag);
        int n;
        bit push_ok, pop_ok;
        n        = model_q.size();
        wr_en    = we;
        wr_data  = wd;
        r_en     = re;
        flag_clr = fc;
        push_ok  = we && (n < DEPTH || re);
        pop_ok   = re && (n > 0);
        m_ovf    = (we && n == DEPTH && !re) || (m_ovf && !fc);
        m_unf    = (re && n == 0) || (m_unf && !fc);
        m_int    = (pop_ok && !push_ok && n == 1) || (m_int && !fc);
        if (pop_ok)  sb_q.push_back(model_q.pop_front());
        if (push_ok) model_q.push_back(wd);
        @(posedge clk_uart);
        #1;
        check_state(tag);
        wr_en    = 1'b0;
        r_en     = 1'b0;
        flag_clr = 1'b0;
    endtask

    // Monitor: every accepted pop must deliver the next byte the model released.
    always @(negedge clk_uart) begin
        if (!rst && r_en && !fifo_empty) begin
            if (sb_q.size() == 0) begin
                check("pop_unexpected", 32'd1, 32'd0);
            end else begin
                check("pop_data", 32'(txd_from_fifo), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; r_en = 1'b0; flag_clr = 1'b0; wr_data = '0;
        m_ovf = 1'b0; m_unf = 1'b0; m_int = 1'b0;
        repeat (2) @(posedge clk_uart);
        #1;
        check_state("reset");
        rst = 1'b0;

        // Single byte through, drain raises the interrupt.
        step(1'b1, 8'hD9, 1'b0, 1'b0, "t1_push");
        step(1'b0, 8'h00, 1'b1, 1'b0, "t1_pop");
        check("t1 tx_empty_int set", 32'(tx_empty_int), 32'd1);

        // Fill to full, overflow, drain in order.
        step(1'b0, 8'h00, 1'b0, 1'b1, "t2_clr");
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "t2_fill");
        step(1'b1, 8'hEE, 1'b0, 1'b0, "t2_ovf");
        check("t2 ovf set", 32'(ovf), 32'd1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "t2_drain");

        // Simultaneous push/pop on a full FIFO.
        step(1'b0, 8'h00, 1'b0, 1'b1, "t3_clr");
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "t3_fill");
        step(1'b1, 8'hAA, 1'b1, 1'b0, "t3_both_full");
        check("t3 head advanced", 32'(txd_from_fifo), 32'h01);
        check("t3 no ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "t3_drain");

        // Underflow and simultaneous push/pop on an empty FIFO.
        step(1'b0, 8'h00, 1'b0, 1'b1, "t4_clr");
        step(1'b0, 8'h00, 1'b1, 1'b0, "t4_unf");
        check("t4 unf set", 32'(unf), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, "t4_clr2");
        step(1'b1, 8'h55, 1'b1, 1'b0, "t4_both_empty");
        check("t4 head 55", 32'(txd_from_fifo), 32'h55);
        step(1'b0, 8'h00, 1'b1, 1'b0, "t4_pop");

        // Pointer wrap with steady occupancy, then random traffic.
        begin
            int k;
            k = $urandom_range(1, DEPTH - 1);
            for (int i = 0; i < k; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, "t5_prefill");
            for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0, "t5_pair");
        end
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 9) < 6), 8'($urandom), 1'($urandom_range(0, 9) < 5),
                 1'($urandom_range(0, 9) == 0), "t5_rand");
        end
        while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0, "t5_drain");
        step(1'b0, 8'h00, 1'b0, 1'b1, "t5_clr");
        check("t5 ovf cleared", 32'(ovf), 32'd0);
        check("t5 unf cleared", 32'(unf), 32'd0);
        check("t5 int cleared", 32'(tx_empty_int), 32'd0);

        // Asynchronous reset mid-stream with flags raised.
        step(1'b0, 8'h00, 1'b1, 1'b0, "t6_unf");
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, "t6_fill");
        #3;
        rst = 1'b1;
        #1;
        model_q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_int = 1'b0;
        check_state("t6_reset");
        @(posedge clk_uart);
        #1;
        rst = 1'b0;
        step(1'b1, 8'h3C, 1'b0, 1'b0, "t6_push_after");
        step(1'b0, 8'h00, 1'b1, 1'b0, "t6_pop_after");

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
